// File: rtl/global_types.sv
// Shared types for the packet arbiter slice.
//   avln_st     : one beat of an Avalon-ST-like packet stream
//   arb_state_t : arbiter ownership state
//   sat_add16   : 16-bit saturating add of a small increment
package global_types;

  localparam int DATA_W  = 32;
  localparam int EMPTY_W = 2;

  typedef struct packed {
    logic               valid;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [DATA_W-1:0]  data;
  } avln_st;

  typedef enum logic [2:0] {
    IDLE,
    PKT0,
    PKT1,
    DROP0,
    DROP1
  } arb_state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/pkt_arbiter_rr_grant2.sv
// Two-way round-robin grant, purely combinational.
//   req  : per-port request
//   last : port granted most recently
//   gnt  : one-hot grant (zero when nobody requests)
module rr_grant2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Contention: the port that did not win last time goes first.
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/pkt_arbiter.sv
// Merges two packet streams into one without interleaving packets.
// Whole packets are granted round-robin; packets longer than MAX_PKT_LEN
// are cut with a forced eop and their tail is discarded. A long idle spell
// on the output raises flush_req for the downstream FIFO.
//   sys_clk, reset_n : clock, asynchronous active-low reset
//   in0, in1         : requester streams
//   in_ready         : per-requester accept (combinational)
//   port_en          : per-requester enable for new packet grants
//   flush_inhibit    : masks flush_req
//   out              : registered merged stream (sink never stalls)
//   flush_req        : registered idle-timeout flush request
//   drop_cnt         : saturating count of discarded beats
module pkt_arbiter
  import global_types::*;
#(
  parameter int MAX_PKT_LEN = 2048,
  parameter int IDLE_W      = 24
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  avln_st      in0,
  input  avln_st      in1,
  output logic [1:0]  in_ready,
  input  logic [1:0]  port_en,
  input  logic        flush_inhibit,
  output avln_st      out,
  output logic        flush_req,
  output logic [15:0] drop_cnt
);

  localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

  arb_state_t        state_reg, state_next;
  logic              last_reg, last_next;
  logic [CNT_W-1:0]  beat_cnt_reg, beat_cnt_next;
  logic [IDLE_W-1:0] idle_cnt_reg;
  avln_st            out_reg;
  logic              flush_req_reg;
  logic [15:0]       drop_cnt_reg;

  avln_st            in_arr [2];
  logic [1:0]        elig;
  logic [1:0]        stray;
  logic [1:0]        gnt;

  // Per-cycle decisions
  logic              take;       // forward the selected beat this cycle
  logic              sel;        // port whose beat is considered
  logic              force_eop;  // truncation beat
  logic [CNT_W-1:0]  cnt_cand;   // packet beat count including this beat
  logic [1:0]        drop_inc;
  avln_st            beat;

  assign in_arr[0] = in0;
  assign in_arr[1] = in1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign elig[gi]  = in_arr[gi].valid & in_arr[gi].sop & port_en[gi];
      // Mid-packet beats with no owner are soaked up so the port cannot wedge.
      assign stray[gi] = in_arr[gi].valid & ~in_arr[gi].sop;
    end
  endgenerate

  rr_grant2 u_grant (
    .req  (elig),
    .last (last_reg),
    .gnt  (gnt)
  );

  always_comb begin
    state_next    = state_reg;
    last_next     = last_reg;
    beat_cnt_next = beat_cnt_reg;
    in_ready      = 2'b00;
    take          = 1'b0;
    sel           = 1'b0;
    force_eop     = 1'b0;
    cnt_cand      = CNT_W'(1);
    drop_inc      = 2'd0;

    case (state_reg)
      IDLE: begin
        in_ready = gnt | stray;
        drop_inc = {1'b0, stray[0]} + {1'b0, stray[1]};
        sel      = gnt[1];
        take     = |gnt;
        cnt_cand = CNT_W'(1);
      end
      PKT0, PKT1: begin
        sel           = (state_reg == PKT1);
        in_ready[sel] = 1'b1;
        take          = in_arr[sel].valid;
        cnt_cand      = beat_cnt_reg + CNT_W'(1);
      end
      DROP0, DROP1: begin
        sel           = (state_reg == DROP1);
        in_ready[sel] = 1'b1;
        if (in_arr[sel].valid) begin
          drop_inc = 2'd1;
          if (in_arr[sel].eop) begin
            state_next = IDLE;
            last_next  = sel;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    beat = in_arr[sel];

    if (take) begin
      beat_cnt_next = cnt_cand;
      if (beat.eop) begin
        state_next = IDLE;
        last_next  = sel;
      end else if (cnt_cand == CNT_W'(MAX_PKT_LEN)) begin
        force_eop  = 1'b1;
        state_next = sel ? DROP1 : DROP0;
      end else begin
        state_next = sel ? PKT1 : PKT0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      last_reg      <= 1'b1;
      beat_cnt_reg  <= '0;
      idle_cnt_reg  <= '0;
      out_reg       <= '0;
      flush_req_reg <= 1'b0;
      drop_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      beat_cnt_reg <= beat_cnt_next;

      out_reg.valid <= take;
      out_reg.sop   <= take & beat.sop;
      out_reg.eop   <= take & (beat.eop | force_eop);
      // data/empty keep their last value between forwarded beats
      if (take) begin
        out_reg.data  <= beat.data;
        out_reg.empty <= force_eop ? '0 : beat.empty;
      end

      if (out_reg.valid)
        idle_cnt_reg <= '0;
      else if (idle_cnt_reg != '1)
        idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);

      flush_req_reg <= (&idle_cnt_reg) & ~flush_inhibit;
      drop_cnt_reg  <= sat_add16(drop_cnt_reg, drop_inc);
    end
  end

  assign out       = out_reg;
  assign flush_req = flush_req_reg;
  assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_pkt_arbiter.sv
// Directed scoreboard bench for pkt_arbiter (MAX_PKT_LEN=4, IDLE_W=4).
// Stimulus pushes expected output beats into a queue; a negedge monitor
// pops and compares every beat the DUT presents.
module tb_pkt_arbiter;
  import global_types::*;

  typedef struct {
    avln_st b;
    int     cyc;  // expected cycle number, -1 = don't care
  } exp_t;

  logic        sys_clk;
  logic        reset_n;
  avln_st      in0, in1, out;
  logic [1:0]  in_ready;
  logic [1:0]  port_en;
  logic        flush_inhibit;
  logic        flush_req;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t   exp_q[$];
  avln_st q0[$];
  avln_st q1[$];
  exp_t   mon_e;

  pkt_arbiter #(.MAX_PKT_LEN(4), .IDLE_W(4)) dut (
    .sys_clk       (sys_clk),
    .reset_n       (reset_n),
    .in0           (in0),
    .in1           (in1),
    .in_ready      (in_ready),
    .port_en       (port_en),
    .flush_inhibit (flush_inhibit),
    .out           (out),
    .flush_req     (flush_req),
    .drop_cnt      (drop_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  function automatic avln_st mk(input logic [31:0] d, input logic s, input logic e,
                                input logic [1:0] em);
    avln_st b;
    b.valid = 1'b1; b.sop = s; b.eop = e; b.empty = em; b.data = d;
    return b;
  endfunction

  task automatic push_exp(input avln_st b, input int c);
    exp_t e;
    e.b = b; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, expv);
    end else
      $display("ok   %s = %0h", name, got);
  endtask

  // Scoreboard monitor
  always @(negedge sys_clk) begin
    if (reset_n && out.valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out got data=%h sop=%b eop=%b cyc=%0d exp=none",
                 out.data, out.sop, out.eop, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (out.data !== mon_e.b.data || out.sop !== mon_e.b.sop || out.eop !== mon_e.b.eop ||
            out.empty !== mon_e.b.empty || (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
          bad++;
          $display("FAIL out_beat got d=%h s=%b e=%b em=%0d cyc=%0d exp d=%h s=%b e=%b em=%0d cyc=%0d",
                   out.data, out.sop, out.eop, out.empty, cyc,
                   mon_e.b.data, mon_e.b.sop, mon_e.b.eop, mon_e.b.empty, mon_e.cyc);
        end else
          $display("ok   out_beat d=%h s=%b e=%b em=%0d cyc=%0d",
                   out.data, out.sop, out.eop, out.empty, cyc);
      end
    end
  end

  // Drive queued beats (called at a negedge); invalid entries are idle cycles.
  task automatic run();
    int n;
    logic [1:0] rdy;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 300) begin
      in0 = (q0.size() > 0) ? q0[0] : '0;
      in1 = (q1.size() > 0) ? q1[0] : '0;
      #1 rdy = in_ready;
      @(posedge sys_clk);
      if (q0.size() > 0 && (!q0[0].valid || rdy[0])) void'(q0.pop_front());
      if (q1.size() > 0 && (!q1[0].valid || rdy[1])) void'(q1.pop_front());
      @(negedge sys_clk);
      n++;
    end
    in0 = '0;
    in1 = '0;
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL run_timeout got=%0d cycles exp<300", n);
    end
  endtask

  int base;

  initial begin
    reset_n = 1'b0; port_en = 2'b11; flush_inhibit = 1'b0;
    in0 = mk(32'h1, 1'b1, 1'b0, 2'd0); in1 = '0;
    #1;
    chk("reset_in_ready_grant0", in_ready, 2'b01);
    chk("reset_out_zero", out, 0);
    chk("reset_flush", flush_req, 0);
    chk("reset_drop", drop_cnt, 0);
    in0 = '0;
    @(negedge sys_clk); @(negedge sys_clk);
    reset_n = 1'b1;

    // Simultaneous 3-beat packets: port 0 whole, then port 1 whole
    @(negedge sys_clk); base = cyc;
    q0 = '{mk(32'h0A01,1,0,0), mk(32'h0A02,0,0,0), mk(32'h0A03,0,1,1)};
    q1 = '{mk(32'h0B01,1,0,0), mk(32'h0B02,0,0,0), mk(32'h0B03,0,1,2)};
    foreach (q0[i]) push_exp(q0[i], base + 1 + i);
    foreach (q1[i]) push_exp(q1[i], base + 4 + i);
    run();
    chk("pkts_no_drop", drop_cnt, 0);

    // Round robin with single-beat packets, port 1 joins late
    base = cyc;
    q0 = '{mk(32'hC0,1,1,0), mk(32'hC1,1,1,0), mk(32'hC2,1,1,0),
           mk(32'hC3,1,1,0), mk(32'hC4,1,1,0), mk(32'hC5,1,1,0)};
    q1 = '{avln_st'('0), avln_st'('0), mk(32'hD0,1,1,0), mk(32'hD1,1,1,0), mk(32'hD2,1,1,0)};
    push_exp(q0[0], base+1); push_exp(q0[1], base+2); push_exp(q1[2], base+3);
    push_exp(q0[2], base+4); push_exp(q1[3], base+5); push_exp(q0[3], base+6);
    push_exp(q1[4], base+7); push_exp(q0[4], base+8); push_exp(q0[5], base+9);
    run();

    // 6-beat packet truncated at 4 beats, tail dropped
    base = cyc;
    q0 = '{mk(32'hE0,1,0,0), mk(32'hE1,0,0,0), mk(32'hE2,0,0,0),
           mk(32'hE3,0,0,2), mk(32'hE4,0,0,0), mk(32'hE5,0,1,3)};
    push_exp(q0[0], base+1); push_exp(q0[1], base+2); push_exp(q0[2], base+3);
    push_exp(mk(32'hE3,0,1,0), base+4);
    run();
    chk("trunc_drop_cnt", drop_cnt, 2);
    q0 = '{mk(32'hE8,1,0,0), mk(32'hE9,0,1,1)};
    push_exp(q0[0], -1); push_exp(q0[1], -1);
    run();

    // Stray non-sop beat on port 1 while idle
    in1 = mk(32'hF1, 0, 0, 0);
    #1 chk("stray_in_ready", in_ready, 2'b10);
    @(negedge sys_clk);
    in1 = '0;
    chk("stray_no_valid", out.valid, 0);
    chk("stray_drop_cnt", drop_cnt, 3);

    // Mid-packet sop and port_en drop do not disturb the packet
    base = cyc;
    q1 = '{mk(32'h61,1,0,0), mk(32'h62,1,0,0), mk(32'h63,0,1,1)};
    foreach (q1[i]) push_exp(q1[i], base + 1 + i);
    fork
      run();
      begin @(posedge sys_clk); #1 port_en = 2'b01; end
    join
    in1 = mk(32'h64, 1, 1, 0);
    #1 chk("port_en_blocks", in_ready, 2'b00);
    in1 = '0; port_en = 2'b11;

    // Reset in the middle of a port-1 packet
    @(negedge sys_clk); base = cyc;
    in1 = mk(32'h71, 1, 0, 0); push_exp(in1, base+1);
    @(negedge sys_clk);
    in1 = mk(32'h72, 0, 0, 0); push_exp(in1, base+2);
    @(negedge sys_clk);
    #2 reset_n = 1'b0; in1 = '0;
    #1;
    chk("rst_out_zero", out, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_flush", flush_req, 0);
    @(negedge sys_clk);
    reset_n = 1'b1;

    // Idle flush timing, then port 0 wins the first grant after reset
    repeat (15) @(negedge sys_clk);
    chk("flush_c15", flush_req, 0);
    @(negedge sys_clk);
    chk("flush_c16", flush_req, 1);
    base = cyc;
    q0 = '{mk(32'h81,1,1,0)};
    q1 = '{mk(32'h91,1,1,1)};
    push_exp(q0[0], base+1); push_exp(q1[0], base+2);
    run();
    @(negedge sys_clk);
    chk("flush_clear", flush_req, 0);
    flush_inhibit = 1'b1;
    repeat (20) @(negedge sys_clk);
    chk("flush_inhibit", flush_req, 0);
    flush_inhibit = 1'b0;
    @(negedge sys_clk);
    chk("flush_release", flush_req, 1);

    repeat (3) @(negedge sys_clk);
    chk("exp_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pkt_arbiter.md
PKT_ARBITER -- requirements
Module: pkt_arbiter

Interface
REQ-001 SHALL have parameter MAX_PKT_LEN, default 2048, meaning maximum beats per forwarded packet before forced truncation.
REQ-002 SHALL have parameter IDLE_W, default 24, meaning idle-counter width governing flush request.
REQ-003 SHALL have port sys_clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in0  input  avln_st  packet stream, requester 0.
REQ-006 SHALL have port in1  input  avln_st  packet stream, requester 1.
REQ-007 SHALL have port in_ready  output  2  per-requester accept; a beat transfers when in_i.valid & in_ready[i].
REQ-008 SHALL have port port_en  input  2  per-requester enable for new-packet grants.
REQ-009 SHALL have port flush_inhibit  input  1  suppresses flush_req.
REQ-010 SHALL have port out  output  avln_st  merged stream to delay FIFO (sink always accepts).
REQ-011 SHALL have port flush_req  output  1  requests downstream FIFO flush after long idle.
REQ-012 SHALL have port drop_cnt  output  16  saturating count of discarded beats.

Function
REQ-013 SHALL implement states IDLE, PKT0, PKT1, DROP0, DROP1.
REQ-014 In IDLE, requester i SHALL be eligible when in_i.valid & in_i.sop & port_en[i].
REQ-015 In IDLE, grant SHALL be round-robin: with both eligible, the port not granted last wins; after reset port 0 wins first.
REQ-016 in_ready SHALL be combinational: 1 for the IDLE grantee, the owning port in PKTi/DROPi, and any IDLE port presenting valid & ~sop; 0 otherwise.
REQ-017 Granted sop beat SHALL be forwarded; state -> PKTi unless the beat has eop, then stays IDLE and last-grant <= i.
REQ-018 In PKTi, every accepted beat of port i SHALL be forwarded; on eop state -> IDLE, last-grant <= i; other port's in_ready = 0.
REQ-019 Valid non-sop beats on a non-owning port in IDLE SHALL be accepted and discarded (drop_cnt += 1).
REQ-020 Beat count per packet SHALL start at 1 on sop; the beat making count == MAX_PKT_LEN without eop SHALL be forwarded with eop=1, empty=0, and state -> DROPi.
REQ-021 In DROPi, port i beats SHALL be accepted and discarded (each counted) through its eop inclusive, then -> IDLE, last-grant <= i.
REQ-022 A sop arriving on the owning port in PKTi SHALL be forwarded unmodified (no resynchronisation).
REQ-023 port_en falling mid-packet SHALL NOT truncate; the packet completes.
REQ-024 out SHALL be registered: accepted beat appears exactly 1 cycle later; out.valid/sop/eop = 0 on cycles with no forwarded beat; data/empty hold last value.
REQ-025 Idle counter SHALL increment on cycles with out.valid = 0, saturate at all-ones, clear when out.valid = 1.
REQ-026 flush_req SHALL be registered: 1 while idle counter is all-ones and flush_inhibit = 0.
REQ-027 drop_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-028 On reset_n low: state IDLE, last-grant = 1, beat count 0, idle counter 0, out all zero, flush_req 0, drop_cnt 0; in_ready evaluates from IDLE.
REQ-029 Reset mid-packet SHALL abandon the packet without emitting a terminating eop.

Structure
REQ-030 State enum (arb_state_t) and avln_st SHALL live in global_types.
REQ-031 Grant logic SHALL be a sub-module rr_grant2 (req[1:0], last, gnt[1:0]), combinational.

Verification
REQ-032 Both ports present 3-beat packets with sop simultaneously after reset -> out carries port-0 packet (beats at cycles 1..3), then port-1 packet; no interleave.
REQ-033 Port 0 sends single-beat sop&eop packets continuously, port 1 idle-to-active -> grants alternate 0,1,0,1 once port 1 requests.
REQ-034 MAX_PKT_LEN=4, port 0 sends 6-beat packet -> out shows 4 beats, beat 4 eop=1 empty=0; beats 5-6 dropped; drop_cnt = 2.
REQ-035 Port 1 sends non-sop beat while IDLE -> in_ready[1]=1, no out.valid, drop_cnt increments by 1.
REQ-036 IDLE_W=4, no traffic 15 cycles after reset -> flush_req = 1 on cycle 16; goes 0 one cycle after first forwarded beat; flush_inhibit=1 keeps it 0.
REQ-037 reset_n pulsed low during PKT1 -> all outputs zero, next grant goes to port 0.
